riscv_if_stage: RTL and testbench

Instruction-fetch stage directly upstream of the ID stage. It owns the PC and issues one outstanding request at a time to instruction memory over a valid/ready request/response pair. It holds each fetched instruction with its PC in an output register until ID accepts it. Redirects from EX (branch, jump, trap) squash in-flight work and restart fetch at the new target.

---
 rtl/riscv_if_stage_pkg.sv | 16 +
 rtl/riscv_if_stage_pc.sv | 35 +++
 rtl/riscv_if_stage.sv | 92 +++++++++
 tb/tb_riscv_if_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_if_stage_pkg.sv
// rtl/riscv_if_stage_pkg.sv - shared widths, reset PC, state encodings and NOP for the fetch stage
package riscv_if_stage_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] PC_RESET_VAL = 32'h8000_0000;
  localparam logic [INST_WIDTH-1:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_S_REQ  = 2'd0,
    IF_S_WAIT = 2'd1,
    IF_S_OUT  = 2'd2
  } ifState_t;

endpackage

// File: rtl/riscv_if_stage_pc.sv
// rtl/riscv_if_stage_pc.sv - PC register with hold / +4 / word-aligned redirect next-PC mux
module riscv_if_pc
  import riscv_if_stage_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_WIDTH,
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcNext
);

  // Redirect beats advance; low bits are dropped so every fetch stays word aligned.
  always_comb begin
    pcNext = pc;
    if (redirect) begin
      pcNext = {redirectPc[ADDR_W-1:2], 2'b00};
    end else if (advance) begin
      pcNext = pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/riscv_if_stage.sv
// rtl/riscv_if_stage.sv - single-outstanding instruction fetch stage with EX redirect squash
module riscv_if_stage
  import riscv_if_stage_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_WIDTH,
  parameter int                INST_W   = INST_WIDTH,
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  output logic              imem_resp_ready,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  ifState_t          state;
  logic              squash;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] reqAddr;
  logic              respFire;
  logic              respAccept;

  assign respFire   = (state == IF_S_WAIT) && imem_resp_valid;
  assign respAccept = respFire && !squash && !redirect_valid;

  riscv_if_pc #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect_valid),
    .redirectPc (redirect_pc),
    .advance    (respAccept),
    .pc         (pc),
    .pcNext     (pcNext)
  );

  // reqAddr is latched on entry to S_REQ so a redirect cannot disturb a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IF_S_REQ;
      squash  <= 1'b0;
      reqAddr <= PC_RESET;
      if_pc   <= '0;
      if_inst <= '0;
    end else begin
      case (state)
        IF_S_REQ: begin
          if (redirect_valid) squash <= 1'b1;
          if (imem_req_ready) state <= IF_S_WAIT;
        end
        IF_S_WAIT: begin
          if (respAccept) begin
            if_inst <= imem_resp_data;
            if_pc   <= pc;
            state   <= IF_S_OUT;
          end else if (respFire) begin
            squash  <= 1'b0;
            reqAddr <= pcNext;
            state   <= IF_S_REQ;
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end
        IF_S_OUT: begin
          if (redirect_valid || id_ready) begin
            reqAddr <= pcNext;
            state   <= IF_S_REQ;
          end
        end
        default: state <= IF_S_REQ;
      endcase
    end
  end

  assign imem_req_valid  = rst_n && (state == IF_S_REQ);
  assign imem_req_addr   = reqAddr;
  assign imem_resp_ready = (state == IF_S_WAIT);
  assign if_valid        = (state == IF_S_OUT);

endmodule

// File: tb/tb_riscv_if_stage.sv
// tb/tb_riscv_if_stage.sv - directed self-checking bench for riscv_if_stage
module tb_riscv_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  logic        pending;
  logic [31:0] pendAddr;

  always #5 clk = ~clk;

  riscv_if_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  // Zero-wait memory: data is the bitwise inverse of the requested address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      pendAddr <= '0;
    end else begin
      if (imem_resp_valid && imem_resp_ready) pending <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pending  <= 1'b1;
        pendAddr <= imem_req_addr;
      end
    end
  end

  assign imem_resp_valid = pending;
  assign imem_resp_data  = ~pendAddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    tick();
    check("rst_if_valid", if_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_resp_ready", imem_resp_ready, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_inst", if_inst, 0);

    tick();
    rst_n = 1'b1;
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    tick();
    check("first_if_valid", if_valid, 1);
    check("first_if_pc", if_pc, 32'h8000_0000);
    check("first_if_inst", if_inst, ~32'h8000_0000);
    tick();
    check("bubble_if_valid", if_valid, 0);
    tick();
    tick();
    check("second_if_valid", if_valid, 1);
    check("second_if_pc", if_pc, 32'h8000_0004);
    tick();
    tick();
    tick();
    check("third_if_valid", if_valid, 1);
    check("third_if_pc", if_pc, 32'h8000_0008);

    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_if_valid", if_valid, 1);
      check("stall_if_pc", if_pc, 32'h8000_0008);
      check("stall_if_inst", if_inst, ~32'h8000_0008);
      check("stall_no_req", imem_req_valid, 0);
    end
    id_ready = 1'b1;
    #1;
    check("release_no_req", imem_req_valid, 0);
    tick();
    check("release_req_valid", imem_req_valid, 1);
    check("release_req_addr", imem_req_addr, 32'h8000_000C);

    #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("stuck_req_valid", imem_req_valid, 1);
    check("stuck_req_addr_c1", imem_req_addr, 32'h8000_0000);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("stuck_req_addr_c3", imem_req_addr, 32'h8000_0000);
    tick();
    tick();
    check("stuck_req_addr_c5", imem_req_addr, 32'h8000_0000);
    tick();
    check("stuck_req_addr_c6", imem_req_addr, 32'h8000_0000);
    imem_req_ready = 1'b1;
    tick();
    check("squash_resp_valid", imem_resp_valid, 1);
    check("squash_if_valid_c7", if_valid, 0);
    tick();
    check("squash_if_valid_c8", if_valid, 0);
    check("squash_next_req_valid", imem_req_valid, 1);
    check("squash_next_req_addr", imem_req_addr, 32'h8000_0100);
    tick();
    tick();
    check("redir_if_valid", if_valid, 1);
    check("redir_if_pc", if_pc, 32'h8000_0100);
    check("redir_if_inst", if_inst, ~32'h8000_0100);

    tick();
    check("seq_req_addr", imem_req_addr, 32'h8000_0104);
    tick();
    check("same_cycle_resp_valid", imem_resp_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0203;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("same_cycle_if_valid", if_valid, 0);
    check("same_cycle_req_valid", imem_req_valid, 1);
    check("same_cycle_req_addr", imem_req_addr, 32'h8000_0200);
    tick();
    tick();
    check("same_cycle_if_pc", if_pc, 32'h8000_0200);

    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("out_redir_if_valid", if_valid, 0);
    check("out_redir_req_addr", imem_req_addr, 32'h8000_0400);
    tick();
    tick();
    check("out_redir_if_pc", if_pc, 32'h8000_0400);

    tick();
    tick();
    check("midwait_resp_ready", imem_resp_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midwait_rst_if_valid", if_valid, 0);
    check("midwait_rst_req_valid", imem_req_valid, 0);
    check("midwait_rst_resp_ready", imem_resp_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("after_rst_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    tick();
    check("after_rst_if_pc", if_pc, 32'h8000_0000);

    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_req_addr", imem_req_addr, 32'h0000_0000);
    tick();
    tick();
    check("wrap_zero_if_pc", if_pc, 32'h0000_0000);
    check("wrap_zero_if_inst", if_inst, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
